// File: rtl/pi_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// pi_ctrl_pkg : shared state encoding, width helpers and saturation functions
// Rev 1.0
// ============================================================================
package pi_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ERR  = 3'd1,
    ST_INT  = 3'd2,
    ST_MUL  = 3'd3,
    ST_SUM  = 3'd4,
    ST_SAT  = 3'd5,
    ST_DONE = 3'd6
  } pi_state_t;

  localparam logic signed [63:0] c_sat_max = 64'sh3FFF_FFFF_FFFF_FFFF;

  function automatic int prod_e_w(input int k_w, input int err_w);
    return k_w + err_w + 1;
  endfunction

  function automatic int prod_a_w(input int k_w, input int acc_w);
    return k_w + acc_w;
  endfunction

  // Shifted product widths plus one guard bit, so P + I can never wrap.
  function automatic int sum_w(input int pe_w, input int pa_w, input int frac);
    return ((pe_w > pa_w) ? pe_w : pa_w) - frac + 1;
  endfunction

  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] value,
                                                    input logic signed [63:0] limit);
    if (value > limit)
      return limit;
    else if (value < -limit)
      return -limit;
    return value;
  endfunction

  function automatic logic signed [63:0] clamp_sym(input logic signed [63:0] value,
                                                   input int width);
    return sat_signed(value, (64'sd1 <<< (width - 1)) - 64'sd1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pi_sat.sv
`default_nettype none
// ============================================================================
// pi_sat : combinational symmetric saturator, output clamped to [-limit,+limit]
// Rev 1.0
// ============================================================================
module pi_sat
  import pi_ctrl_pkg::*;
#(
  parameter int W  = 16,
  parameter int LW = 15
) (
  input  logic signed [W-1:0]  i_value,
  input  logic        [LW-1:0] i_limit,
  output logic signed [W-1:0]  o_value,
  output logic                 o_sat
);

  assign o_value = W'(sat_signed(64'(i_value), 64'(i_limit)));
  assign o_sat   = (o_value != i_value);

endmodule
`default_nettype wire

// File: rtl/pi_ctrl_mc.sv
`default_nettype none
// ============================================================================
// pi_ctrl_mc : multi-channel PI current controller, one shared datapath, 5 cycles/channel
// Rev 1.0
// ============================================================================
module pi_ctrl_mc
  import pi_ctrl_pkg::*;
#(
  parameter int CH    = 2,
  parameter int ERR_W = 12,
  parameter int K_W   = 16,
  parameter int FRAC  = 12,
  parameter int OUT_W = 16,
  parameter int ACC_W = 24
) (
  input  logic                  iClk,
  input  logic                  iRst,
  input  logic                  iStart,
  input  logic [CH*ERR_W-1:0]   iTarget,
  input  logic [CH*ERR_W-1:0]   iMeas,
  input  logic [CH*K_W-1:0]     iKp,
  input  logic [CH*K_W-1:0]     iKi,
  input  logic [OUT_W-2:0]      iOutLim,
  input  logic                  iIntClr,
  output logic [CH*OUT_W-1:0]   oOut,
  output logic [CH-1:0]         oSat,
  output logic                  oBusy,
  output logic                  oDone
);

  localparam int c_ch_w = (CH > 1) ? $clog2(CH) : 1;
  localparam int c_pe_w = prod_e_w(K_W, ERR_W);
  localparam int c_pa_w = prod_a_w(K_W, ACC_W);
  localparam int c_p_w  = c_pe_w - FRAC;
  localparam int c_i_w  = c_pa_w - FRAC;
  localparam int c_s_w  = sum_w(c_pe_w, c_pa_w, FRAC);
  localparam logic [c_ch_w-1:0] c_last    = c_ch_w'(CH - 1);
  localparam logic [ERR_W-2:0]  c_e_lim   = (ERR_W-1)'(clamp_sym(c_sat_max, ERR_W));
  localparam logic [ACC_W-2:0]  c_acc_lim = (ACC_W-1)'(clamp_sym(c_sat_max, ACC_W));

  pi_state_t               r_state, w_state_nxt;
  logic [c_ch_w-1:0]       r_ch;
  logic signed [ERR_W-1:0] r_t   [CH];
  logic signed [ERR_W-1:0] r_m   [CH];
  logic signed [K_W-1:0]   r_kp  [CH];
  logic signed [K_W-1:0]   r_ki  [CH];
  logic signed [ACC_W-1:0] r_acc [CH];
  logic signed [OUT_W-1:0] r_out [CH];
  logic [CH-1:0]           r_sat;
  logic [OUT_W-2:0]        r_lim;
  logic signed [ERR_W:0]   r_e;
  logic signed [c_p_w-1:0] r_p;
  logic signed [c_i_w-1:0] r_i;
  logic signed [c_s_w-1:0] r_s;
  logic                    r_clr_pend;

  logic signed [ERR_W:0]    w_e_raw, w_e_sat;
  logic signed [ACC_W:0]    w_acc_raw, w_acc_sat;
  logic signed [c_pe_w-1:0] w_pprod;
  logic signed [c_pa_w-1:0] w_iprod;
  logic signed [c_s_w-1:0]  w_s_sat;
  logic                     w_s_clip, w_e_unused, w_acc_unused;
  logic                     w_inhibit, w_clr_now;

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: if (iStart) w_state_nxt = ST_ERR;
      ST_ERR:  w_state_nxt = ST_INT;
      ST_INT:  w_state_nxt = ST_MUL;
      ST_MUL:  w_state_nxt = ST_SUM;
      ST_SUM:  w_state_nxt = ST_SAT;
      ST_SAT:  w_state_nxt = (r_ch == c_last) ? ST_DONE : ST_ERR;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign oBusy = (r_state != ST_IDLE);
  assign oDone = (r_state == ST_DONE);

  assign w_e_raw   = (ERR_W+1)'(r_t[r_ch]) - (ERR_W+1)'(r_m[r_ch]);
  assign w_acc_raw = (ACC_W+1)'(r_acc[r_ch]) + (ACC_W+1)'(r_e);
  // Freeze the integrator while the output is clamped and e would push it further out.
  assign w_inhibit = r_sat[r_ch] & (r_e[ERR_W] == r_out[r_ch][OUT_W-1]);
  assign w_pprod   = c_pe_w'(r_kp[r_ch]) * c_pe_w'(r_e);
  assign w_iprod   = c_pa_w'(r_ki[r_ch]) * c_pa_w'(r_acc[r_ch]);
  assign w_clr_now = ((r_state == ST_IDLE) & iIntClr) |
                     ((r_state == ST_DONE) & (iIntClr | r_clr_pend));

  pi_sat #(.W(ERR_W+1), .LW(ERR_W-1)) u_sat_e (
    .i_value(w_e_raw), .i_limit(c_e_lim), .o_value(w_e_sat), .o_sat(w_e_unused)
  );

  pi_sat #(.W(ACC_W+1), .LW(ACC_W-1)) u_sat_acc (
    .i_value(w_acc_raw), .i_limit(c_acc_lim), .o_value(w_acc_sat), .o_sat(w_acc_unused)
  );

  pi_sat #(.W(c_s_w), .LW(OUT_W-1)) u_sat_out (
    .i_value(r_s), .i_limit(r_lim), .o_value(w_s_sat), .o_sat(w_s_clip)
  );

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_ch       <= '0;
      r_lim      <= '0;
      r_e        <= '0;
      r_p        <= '0;
      r_i        <= '0;
      r_s        <= '0;
      r_sat      <= '0;
      r_clr_pend <= 1'b0;
      for (int k = 0; k < CH; k++) begin
        r_t[k]   <= '0;
        r_m[k]   <= '0;
        r_kp[k]  <= '0;
        r_ki[k]  <= '0;
        r_acc[k] <= '0;
        r_out[k] <= '0;
      end
    end else begin
      if (w_clr_now) begin
        r_sat <= '0;
        for (int k = 0; k < CH; k++) r_acc[k] <= '0;
      end
      // A clear requested mid-calculation waits until the DONE cycle.
      if (r_state == ST_IDLE || r_state == ST_DONE) r_clr_pend <= 1'b0;
      else if (iIntClr)                              r_clr_pend <= 1'b1;

      case (r_state)
        ST_IDLE: begin
          if (iStart) begin
            r_ch  <= '0;
            r_lim <= iOutLim;
            for (int k = 0; k < CH; k++) begin
              r_t[k]  <= iTarget[k*ERR_W +: ERR_W];
              r_m[k]  <= iMeas[k*ERR_W +: ERR_W];
              r_kp[k] <= iKp[k*K_W +: K_W];
              r_ki[k] <= iKi[k*K_W +: K_W];
            end
          end
        end
        ST_ERR: r_e <= w_e_sat;
        ST_INT: if (!w_inhibit) r_acc[r_ch] <= ACC_W'(w_acc_sat);
        ST_MUL: begin
          r_p <= c_p_w'(w_pprod >>> FRAC);
          r_i <= c_i_w'(w_iprod >>> FRAC);
        end
        ST_SUM: r_s <= c_s_w'(r_p) + c_s_w'(r_i);
        ST_SAT: begin
          r_out[r_ch] <= OUT_W'(w_s_sat);
          r_sat[r_ch] <= w_s_clip;
          if (r_ch != c_last) r_ch <= r_ch + c_ch_w'(1);
        end
        default: ;
      endcase
    end
  end

  for (genvar gi = 0; gi < CH; gi++) begin : g_out
    assign oOut[gi*OUT_W +: OUT_W] = r_out[gi];
    assign oSat[gi]                = r_sat[gi];
  end

endmodule
`default_nettype wire

// File: tb/tb_pi_ctrl_mc.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_pi_ctrl_mc : directed + randomized bench against an integer PI reference model
// Rev 1.0
// ============================================================================
module tb_pi_ctrl_mc;

  localparam int     CH    = 2;
  localparam int     ERR_W = 12;
  localparam int     K_W   = 16;
  localparam int     OUT_W = 16;
  localparam longint E_MAX = 2047;
  localparam longint A_MAX = 8388607;

  logic                iClk = 1'b0;
  logic                iRst, iStart, iIntClr;
  logic [CH*ERR_W-1:0] iTarget, iMeas;
  logic [CH*K_W-1:0]   iKp, iKi;
  logic [OUT_W-2:0]    iOutLim;
  logic [CH*OUT_W-1:0] oOut;
  logic [CH-1:0]       oSat;
  logic                oBusy, oDone;

  pi_ctrl_mc dut (
    .iClk(iClk), .iRst(iRst), .iStart(iStart), .iTarget(iTarget), .iMeas(iMeas),
    .iKp(iKp), .iKi(iKi), .iOutLim(iOutLim), .iIntClr(iIntClr),
    .oOut(oOut), .oSat(oSat), .oBusy(oBusy), .oDone(oDone)
  );

  always #5 iClk = ~iClk;

  int     n_vec = 0;
  int     n_err = 0;
  longint t_v[CH], m_v[CH], kp_v[CH], ki_v[CH];
  longint lim_v;
  longint m_acc[CH], m_out[CH];
  bit     m_sat[CH];

  task automatic check_val(input string tag, input longint obs, input longint exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  function automatic longint floor_div(input longint a, input longint b);
    longint q = a / b;
    if ((a % b != 0) && ((a < 0) != (b < 0))) q = q - 1;
    return q;
  endfunction

  function automatic longint lim_sym(input longint v, input longint l);
    return (v > l) ? l : ((v < -l) ? -l : v);
  endfunction

  function automatic void model_clear();
    for (int c = 0; c < CH; c++) begin
      m_acc[c] = 0;
      m_sat[c] = 1'b0;
    end
  endfunction

  function automatic void model_reset();
    model_clear();
    for (int c = 0; c < CH; c++) m_out[c] = 0;
  endfunction

  // One full PI update of every channel, in channel order.
  function automatic void model_calc();
    longint e, p, i, s;
    for (int c = 0; c < CH; c++) begin
      e = lim_sym(t_v[c] - m_v[c], E_MAX);
      if (!(m_sat[c] && ((e < 0) == (m_out[c] < 0))))
        m_acc[c] = lim_sym(m_acc[c] + e, A_MAX);
      p = floor_div(kp_v[c] * e, 4096);
      i = floor_div(ki_v[c] * m_acc[c], 4096);
      s = p + i;
      m_out[c] = lim_sym(s, lim_v);
      m_sat[c] = (m_out[c] != s);
    end
  endfunction

  task automatic drive_inputs();
    for (int c = 0; c < CH; c++) begin
      iTarget[c*ERR_W +: ERR_W] = ERR_W'(t_v[c]);
      iMeas[c*ERR_W +: ERR_W]   = ERR_W'(m_v[c]);
      iKp[c*K_W +: K_W]         = K_W'(kp_v[c]);
      iKi[c*K_W +: K_W]         = K_W'(ki_v[c]);
    end
    iOutLim = (OUT_W-1)'(lim_v);
  endtask

  function automatic longint out_of(input int c);
    logic signed [OUT_W-1:0] o;
    o = oOut[c*OUT_W +: OUT_W];
    return longint'(o);
  endfunction

  task automatic check_outputs(input string tag);
    for (int c = 0; c < CH; c++) begin
      check_val($sformatf("%s_out%0d", tag, c), out_of(c), m_out[c]);
      check_val($sformatf("%s_sat%0d", tag, c), longint'(oSat[c]), longint'(m_sat[c]));
    end
  endtask

  task automatic idle_clear(input string tag);
    iIntClr = 1'b1;
    tick();
    iIntClr = 1'b0;
    model_clear();
    check_val({tag, "_clrsat"}, longint'(oSat), 0);
  endtask

  task automatic run_calc(input string tag, input bit clr_start, input bit clr_mid);
    int n;
    bit busy_ok;
    drive_inputs();
    iStart  = 1'b1;
    iIntClr = clr_start;
    tick();
    iStart  = 1'b0;
    iIntClr = 1'b0;
    if (clr_start) model_clear();
    model_calc();
    n = 1;
    busy_ok = 1'b1;
    while (!oDone && n < 40) begin
      if (!oBusy) busy_ok = 1'b0;
      if (clr_mid && n == 3) iIntClr = 1'b1;
      tick();
      iIntClr = 1'b0;
      n++;
    end
    check_val({tag, "_latency"}, n, 11);
    check_val({tag, "_busy"}, longint'(busy_ok & oBusy), 1);
    check_outputs(tag);
    tick();
    if (clr_mid) model_clear();
    check_val({tag, "_idle"}, longint'({oBusy, oDone}), 0);
    check_val({tag, "_satpost"}, longint'(oSat), longint'({m_sat[1], m_sat[0]}));
  endtask

  task automatic set_ch(input int c, input longint t, input longint m,
                        input longint kp, input longint ki);
    t_v[c] = t; m_v[c] = m; kp_v[c] = kp; ki_v[c] = ki;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout, expected self-termination");
    $fatal(1);
  end

  initial begin
    int  n;
    bit  seen;
    iRst = 1'b1; iStart = 1'b0; iIntClr = 1'b0;
    for (int c = 0; c < CH; c++) set_ch(c, 0, 0, 0, 0);
    lim_v = 32767;
    drive_inputs();
    model_reset();
    tick(); tick();
    iRst = 1'b0;
    tick();
    check_val("rst_out", longint'(oOut), 0);
    check_val("rst_flags", longint'({oSat, oBusy, oDone}), 0);

    // Pure proportional channel 0
    set_ch(0, 100, 40, 4096, 0);
    run_calc("t1", 1'b0, 1'b0);
    check_val("t1_lit", out_of(0), 60);

    // Pure integral channel 1, three updates then an idle clear
    set_ch(1, 10, 0, 0, 4096);
    for (int k = 1; k <= 3; k++) begin
      run_calc($sformatf("t2_%0d", k), 1'b0, 1'b0);
      check_val($sformatf("t2_lit%0d", k), out_of(1), 10 * k);
    end
    idle_clear("t2");
    run_calc("t2_4", 1'b0, 1'b0);
    check_val("t2_lit4", out_of(1), 10);

    // Output limit and anti-windup
    idle_clear("t3");
    lim_v = 1000;
    set_ch(0, 2047, 0, 16384, 4096);
    run_calc("t3_a", 1'b0, 1'b0);
    check_val("t3_lim", out_of(0), 1000);
    check_val("t3_satf", longint'(oSat[0]), 1);
    run_calc("t3_b", 1'b0, 1'b0);
    set_ch(0, -50, 0, 16384, 4096);
    run_calc("t3_c", 1'b0, 1'b0);
    lim_v = 32767;
    set_ch(0, 0, 0, 0, 4096);
    run_calc("t3_d", 1'b0, 1'b0);
    check_val("t3_acc", out_of(0), 1997);

    // Error clamp and floor rounding
    idle_clear("t4");
    set_ch(0, -2048, 2047, 4096, 0);
    run_calc("t4_a", 1'b0, 1'b0);
    check_val("t4_neg", out_of(0), -2047);
    set_ch(0, -2048, 0, -4096, 0);
    run_calc("t4_b", 1'b0, 1'b0);
    check_val("t4_pos", out_of(0), 2047);
    set_ch(0, -3, 0, 2048, 0);
    run_calc("t4_c", 1'b0, 1'b0);
    check_val("t4_floor", out_of(0), -2);

    // Snapshot, dropped restart and deferred clear
    lim_v = 100;
    set_ch(0, 2000, -40, 16384, 4096);
    set_ch(1, -1500, 300, 16384, 100);
    drive_inputs();
    iStart = 1'b1;
    tick();
    iStart = 1'b0;
    model_calc();
    n = 1;
    while (!oDone && n < 40) begin
      if (n == 2) begin
        for (int c = 0; c < CH; c++)
          set_ch(c, longint'($urandom_range(0, 4095)) - 2048, 0, 1000, 0);
        lim_v = 30000;
        drive_inputs();
      end
      if (n == 4) begin
        iStart = 1'b1;
        iIntClr = 1'b1;
      end
      tick();
      iStart = 1'b0;
      iIntClr = 1'b0;
      n++;
    end
    check_val("t5_latency", n, 11);
    check_outputs("t5");
    tick();
    model_clear();
    check_val("t5_satclr", longint'(oSat), 0);
    seen = 1'b0;
    for (int k = 0; k < 15; k++) begin
      if (oBusy || oDone) seen = 1'b1;
      tick();
    end
    check_val("t5_dropped", longint'(seen), 0);
    lim_v = 32767;
    set_ch(0, 5, 0, 0, 4096);
    set_ch(1, -7, 0, 0, 4096);
    run_calc("t5_acc", 1'b0, 1'b0);

    // Asynchronous reset in the middle of a calculation
    set_ch(0, 700, 100, 8192, 2048);
    set_ch(1, -900, 50, 4096, 1024);
    drive_inputs();
    iStart = 1'b1;
    tick();
    iStart = 1'b0;
    for (int k = 1; k < 6; k++) tick();
    iRst = 1'b1;
    #1;
    check_val("t6_out", longint'(oOut), 0);
    check_val("t6_flags", longint'({oSat, oBusy, oDone}), 0);
    tick();
    iRst = 1'b0;
    model_reset();
    seen = 1'b0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (oDone) seen = 1'b1;
    end
    check_val("t6_nodone", longint'(seen), 0);
    run_calc("t6_after", 1'b0, 1'b0);

    // Randomized updates with random clears and limits
    for (int r = 0; r < 40; r++) begin
      for (int c = 0; c < CH; c++)
        set_ch(c, longint'($urandom_range(0, 4095)) - 2048,
                  longint'($urandom_range(0, 4095)) - 2048,
                  longint'($urandom_range(0, 65535)) - 32768,
                  longint'($urandom_range(0, 8191)) - 4096);
      lim_v = ($urandom_range(0, 1) == 1) ? 32767 : longint'($urandom_range(0, 2000));
      if ($urandom_range(0, 9) == 0) idle_clear($sformatf("rnd%0d", r));
      run_calc($sformatf("rnd%0d", r), ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
